// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction fetch stage.
package otter_fetch_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetch_state_t;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/otter_fetch_unit_if.sv
// Fetch-stage bus: redirect input, instruction-memory req/ack, decode valid/ready.
interface otter_fetch_unit_if;

    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic [31:0] PC;

    modport master (
        input  REDIRECT, REDIRECT_PC, IMEM_ACK, IMEM_RDATA, INSTR_READY,
        output IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR, INSTR_PC, PC
    );

    modport slave (
        output REDIRECT, REDIRECT_PC, IMEM_ACK, IMEM_RDATA, INSTR_READY,
        input  IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR, INSTR_PC, PC
    );

endinterface

// File: rtl/otter_pc_reg.sv
// Program counter: loads either PC+4 or the word-aligned redirect target.
module otter_pc_reg
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        sel_redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else if (load) begin
            pc <= sel_redirect ? align_word(redirect_pc) : pc + 32'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER fetch stage: owns the PC, issues one outstanding imem request, and
// holds at most one fetched instruction for decode.
module otter_fetch_unit
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
    input  logic               CLK,
    input  logic               RST,
    otter_fetch_unit_if.master bus
);

    fetch_state_t state, next_state;

    logic [31:0] pc, target;
    logic        pc_load, pc_sel;
    logic        deliver, clear_valid, addr_load;
    logic [31:0] addr_next;
    logic [31:0] imem_addr_q, instr_q, instr_pc_q;
    logic        instr_valid_q;

    assign target = align_word(bus.REDIRECT_PC);

    otter_pc_reg #(.RESET_VEC(RESET_VEC)) u_pc (
        .clk          (CLK),
        .rst          (RST),
        .load         (pc_load),
        .sel_redirect (pc_sel),
        .redirect_pc  (bus.REDIRECT_PC),
        .pc           (pc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        pc_load     = 1'b0;
        pc_sel      = 1'b0;
        deliver     = 1'b0;
        clear_valid = 1'b0;
        addr_load   = 1'b0;
        addr_next   = pc;
        case (state)
            IDLE: begin
                next_state = FETCH;
                addr_load  = 1'b1;
                if (bus.REDIRECT) begin
                    pc_load   = 1'b1;
                    pc_sel    = 1'b1;
                    addr_next = target;
                end
            end
            FETCH: begin
                if (bus.REDIRECT) begin
                    pc_load = 1'b1;
                    pc_sel  = 1'b1;
                    if (bus.IMEM_ACK) begin
                        addr_load = 1'b1;
                        addr_next = target;
                    end else begin
                        next_state = DISCARD;
                    end
                end else if (bus.IMEM_ACK) begin
                    deliver    = 1'b1;
                    pc_load    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.REDIRECT) begin
                    clear_valid = 1'b1;
                    pc_load     = 1'b1;
                    pc_sel      = 1'b1;
                    addr_load   = 1'b1;
                    addr_next   = target;
                    next_state  = FETCH;
                end else if (instr_valid_q && bus.INSTR_READY) begin
                    clear_valid = 1'b1;
                    addr_load   = 1'b1;
                    next_state  = FETCH;
                end
            end
            DISCARD: begin
                if (bus.REDIRECT) begin
                    pc_load = 1'b1;
                    pc_sel  = 1'b1;
                end
                // A redirect coinciding with the stale ack must bypass the PC register.
                if (bus.IMEM_ACK) begin
                    addr_load  = 1'b1;
                    addr_next  = bus.REDIRECT ? target : pc;
                    next_state = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            imem_addr_q   <= RESET_VEC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            if (addr_load) imem_addr_q <= addr_next;
            if (deliver) begin
                instr_valid_q <= 1'b1;
                instr_q       <= bus.IMEM_RDATA;
                instr_pc_q    <= imem_addr_q;
            end else if (clear_valid) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.IMEM_REQ    = (state == FETCH) || (state == DISCARD);
    assign bus.IMEM_ADDR   = imem_addr_q;
    assign bus.INSTR_VALID = instr_valid_q;
    assign bus.INSTR       = instr_q;
    assign bus.INSTR_PC    = instr_pc_q;
    assign bus.PC          = pc;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: directed vector table, reset/wrap sequences,
// and randomized traffic checked against an in-order delivery model.
module tb_otter_fetch_unit;

    logic CLK = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 CLK = ~CLK;

    otter_fetch_unit_if fa ();
    otter_fetch_unit_if fb ();

    otter_fetch_unit u_dut (
        .CLK (CLK),
        .RST (rst_a),
        .bus (fa)
    );

    otter_fetch_unit #(.RESET_VEC(32'hFFFF_FFFC)) u_dut_b (
        .CLK (CLK),
        .RST (rst_b),
        .bus (fb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic        ready;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] eipc;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs [22];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic a,
                                input logic rd, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] eipc,
                                input logic [31:0] ein, input logic [31:0] epc);
        vec_t v;
        v.redirect = r;   v.rpc = rpc;     v.ack = a;      v.ready = rd;
        v.ereq = er;      v.eaddr = ea;    v.evalid = ev;  v.eipc = eipc;
        v.einstr = ein;   v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_a(input logic r, input logic [31:0] rpc, input logic a, input logic rd);
        fa.REDIRECT    = r;
        fa.REDIRECT_PC = rpc;
        fa.IMEM_ACK    = a;
        fa.IMEM_RDATA  = a ? memf(fa.IMEM_ADDR) : 32'hDEAD_BEEF;
        fa.INSTR_READY = rd;
    endtask

    always @(posedge CLK) begin
        if (!rst_a)
            assert (!(fa.IMEM_ACK && !fa.IMEM_REQ))
            else begin n_fail++; $display("FAIL protocol_a: ack=%b without req", fa.IMEM_ACK); end
        if (!rst_b)
            assert (!(fb.IMEM_ACK && !fb.IMEM_REQ))
            else begin n_fail++; $display("FAIL protocol_b: ack=%b without req", fb.IMEM_ACK); end
    end

    initial begin
        logic [31:0] f0, f4, f8, f12, f100, f200;
        logic [31:0] exp_pc, prev_addr, prev_ipc, rpc;
        logic        prev_req, prev_ack, prev_valid, prev_ready, prev_redir;
        logic        ready, redir, ack;
        int unsigned age, lat, delivered;

        f0 = memf(32'h0);    f4 = memf(32'h4);      f8 = memf(32'h8);
        f12 = memf(32'hC);   f100 = memf(32'h100);  f200 = memf(32'h200);

        vecs[0]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0, 32'h0);
        vecs[1]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0, 32'h0);
        vecs[2]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   f0,    32'h4);
        vecs[3]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   f0,    32'h4);
        vecs[4]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h4,   1'b1, 32'h4,   f4,    32'h8);
        vecs[5]  = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,   1'b0, 32'h4,   f4,    32'h8);
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8,  1'b1, 32'h8,   f8,    32'hC);
        vecs[11] = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h8,   1'b1, 32'h8,   f8,    32'hC);
        vecs[12] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hC,   1'b0, 32'h8,   f8,    32'hC);
        vecs[13] = mk(1'b1, 32'h103, 1'b0, 1'b0, 1'b0, 32'hC,   1'b1, 32'hC,   f12,   32'h10);
        vecs[14] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'hC,   f12,   32'h100);
        vecs[15] = mk(1'b1, 32'h40,  1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100, f100,  32'h104);
        vecs[16] = mk(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h40,  1'b0, 32'h100, f100,  32'h40);
        vecs[17] = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  1'b0, 32'h100, f100,  32'h200);
        vecs[18] = mk(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  1'b0, 32'h100, f100,  32'h200);
        vecs[19] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h40,  1'b0, 32'h100, f100,  32'h200);
        vecs[20] = mk(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h100, f100,  32'h200);
        vecs[21] = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, f200,  32'h204);

        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        fb.REDIRECT = 1'b0; fb.REDIRECT_PC = '0; fb.IMEM_ACK = 1'b0;
        fb.IMEM_RDATA = '0; fb.INSTR_READY = 1'b1;

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_req",   32'(fa.IMEM_REQ),    32'h0);
        chk("rst_addr",  fa.IMEM_ADDR,        32'h0);
        chk("rst_valid", 32'(fa.INSTR_VALID), 32'h0);
        chk("rst_instr", fa.INSTR,            32'h0);
        chk("rst_ipc",   fa.INSTR_PC,         32'h0);
        chk("rst_pc",    fa.PC,               32'h0);
        rst_a = 1'b0;

        // Directed vector table
        for (int i = 0; i < 22; i++) begin
            chk($sformatf("v%0d_req", i),   32'(fa.IMEM_REQ),    32'(vecs[i].ereq));
            chk($sformatf("v%0d_addr", i),  fa.IMEM_ADDR,        vecs[i].eaddr);
            chk($sformatf("v%0d_valid", i), 32'(fa.INSTR_VALID), 32'(vecs[i].evalid));
            chk($sformatf("v%0d_ipc", i),   fa.INSTR_PC,         vecs[i].eipc);
            chk($sformatf("v%0d_instr", i), fa.INSTR,            vecs[i].einstr);
            chk($sformatf("v%0d_pc", i),    fa.PC,               vecs[i].epc);
            drive_a(vecs[i].redirect, vecs[i].rpc, vecs[i].ack, vecs[i].ready);
            @(negedge CLK);
        end

        // Reset while a request to 0x8 is outstanding
        drive_a(1'b0, 32'h0, 1'b0, 1'b1);
        rst_a = 1'b1;
        @(negedge CLK);
        rst_a = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b0, 32'h0, fa.IMEM_REQ, 1'b1);
            @(negedge CLK);
        end
        chk("rq_req",  32'(fa.IMEM_REQ), 32'h1);
        chk("rq_addr", fa.IMEM_ADDR,     32'h8);
        drive_a(1'b0, 32'h0, 1'b0, 1'b1);
        #2 rst_a = 1'b1;
        #1;
        chk("rq_async_req",   32'(fa.IMEM_REQ),    32'h0);
        chk("rq_async_pc",    fa.PC,               32'h0);
        chk("rq_async_valid", 32'(fa.INSTR_VALID), 32'h0);
        @(negedge CLK);
        fa.IMEM_ACK = 1'b1; fa.IMEM_RDATA = memf(32'h8);
        @(negedge CLK);
        drive_a(1'b0, 32'h0, 1'b0, 1'b1);
        rst_a = 1'b0;
        chk("rq_idle_addr", fa.IMEM_ADDR, 32'h0);
        chk("rq_idle_req",  32'(fa.IMEM_REQ), 32'h0);
        @(negedge CLK);
        chk("rq_fetch_req",  32'(fa.IMEM_REQ), 32'h1);
        chk("rq_fetch_addr", fa.IMEM_ADDR,     32'h0);
        chk("rq_fetch_valid", 32'(fa.INSTR_VALID), 32'h0);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        chk("rq_deliv_ipc",   fa.INSTR_PC, 32'h0);
        chk("rq_deliv_instr", fa.INSTR,    f0);
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);

        // PC wrap with RESET_VEC = 0xFFFF_FFFC
        @(negedge CLK);
        rst_b = 1'b0;
        chk("wrap_rst_pc",   fb.PC,        32'hFFFF_FFFC);
        chk("wrap_rst_addr", fb.IMEM_ADDR, 32'hFFFF_FFFC);
        @(negedge CLK);
        chk("wrap_req", 32'(fb.IMEM_REQ), 32'h1);
        fb.IMEM_ACK = 1'b1; fb.IMEM_RDATA = memf(32'hFFFF_FFFC);
        @(negedge CLK);
        fb.IMEM_ACK = 1'b0;
        chk("wrap_pc",    fb.PC,       32'h0);
        chk("wrap_ipc",   fb.INSTR_PC, 32'hFFFF_FFFC);
        chk("wrap_instr", fb.INSTR,    memf(32'hFFFF_FFFC));
        @(negedge CLK);
        chk("wrap_next_addr", fb.IMEM_ADDR, 32'h0);
        chk("wrap_next_req",  32'(fb.IMEM_REQ), 32'h1);

        // Randomized traffic against an in-order delivery model
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        rst_a = 1'b1;
        @(negedge CLK);
        rst_a = 1'b0;
        exp_pc = 32'h0; delivered = 0; age = 0; lat = $urandom_range(0, 3);
        prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        prev_redir = 1'b0; prev_addr = '0; prev_ipc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_req && !prev_ack) begin
                chk("rnd_req_held",  32'(fa.IMEM_REQ), 32'h1);
                chk("rnd_addr_held", fa.IMEM_ADDR,     prev_addr);
            end
            if (prev_valid && !prev_ready && !prev_redir) begin
                chk("rnd_valid_held", 32'(fa.INSTR_VALID), 32'h1);
                chk("rnd_ipc_held",   fa.INSTR_PC,         prev_ipc);
            end
            chk("rnd_pc_align", 32'(fa.PC[1:0]), 32'h0);

            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = $urandom;
            ack   = fa.IMEM_REQ && (age >= lat);
            drive_a(redir, rpc, ack, ready);

            if (fa.INSTR_VALID && ready) begin
                chk("rnd_deliv_pc",    fa.INSTR_PC, exp_pc);
                chk("rnd_deliv_instr", fa.INSTR,    memf(exp_pc));
                exp_pc = exp_pc + 32'h4;
                delivered++;
            end
            if (redir) exp_pc = {rpc[31:2], 2'b00};
            if (ack) begin
                age = 0;
                lat = $urandom_range(0, 3);
            end else if (fa.IMEM_REQ) begin
                age++;
            end

            prev_req = fa.IMEM_REQ;  prev_ack = ack;   prev_addr = fa.IMEM_ADDR;
            prev_valid = fa.INSTR_VALID; prev_ready = ready; prev_redir = redir;
            prev_ipc = fa.INSTR_PC;
            @(negedge CLK);
        end
        chk("rnd_progress", 32'(delivered > 200), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
